muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter AW, default 5, giving the destination register address width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request a new operation; sampled only while busy=0.
REQ-006 The block SHALL have port op, input, 2 bits: 00 MUL (low WIDTH of the product), 01 UMULH (high WIDTH of the unsigned product), 10 UDIV, 11 SDIV.
REQ-007 The block SHALL have port a, input, WIDTH bits: first operand (multiplicand or dividend), driven from register-file rd1.
REQ-008 The block SHALL have port b, input, WIDTH bits: second operand (multiplier or divisor), driven from register-file rd2.
REQ-009 The block SHALL have port wa_in, input, AW bits: destination register address.
REQ-010 The block SHALL have port busy, output, 1 bit: an operation is in flight and start is ignored.
REQ-011 The block SHALL have port done, output, 1 bit: a one-cycle pulse marking result and wa_out valid.
REQ-012 The block SHALL have port we, output, 1 bit: register-file write enable, equal to done.
REQ-013 The block SHALL have port result, output, WIDTH bits: the operation result, driven onto register-file wd3.
REQ-014 The block SHALL have port wa_out, output, AW bits: the captured destination address, driven onto register-file wa3.

Function
REQ-015 FSM states SHALL be IDLE, RUN, FIX and DONE; busy=1 exactly in RUN and FIX.
REQ-016 In IDLE or DONE with start=1, the block SHALL capture op, a, b and wa_in, load iteration counter to WIDTH-1, and enter RUN; if start=0, DONE SHALL go to IDLE and IDLE SHALL hold.
REQ-017 Operands SHALL be captured at the start edge; later changes on a, b, op and wa_in SHALL have no effect on the operation in flight.
REQ-018 MUL and UMULH SHALL use a radix-2 shift-add over an unsigned 2*WIDTH-bit product register, one bit per RUN cycle.
REQ-019 UDIV and SDIV SHALL use radix-2 restoring division on magnitudes, one quotient bit per RUN cycle.
REQ-020 For SDIV, the operand magnitudes SHALL be formed at capture, and FIX SHALL negate the quotient when sign(a) XOR sign(b) is 1.
REQ-021 SDIV quotients SHALL truncate toward zero.
REQ-022 RUN SHALL last exactly WIDTH cycles, decrementing the counter each cycle, then go to FIX.
REQ-023 FIX SHALL last one cycle, apply sign correction and result selection, then go to DONE.
REQ-024 done SHALL be asserted exactly WIDTH+2 cycles after the start edge (66 for WIDTH=64).
REQ-025 done SHALL be 1 only in DONE, and SHALL stay high for exactly one cycle per operation.
REQ-026 A divisor of zero (UDIV or SDIV) SHALL produce result 0, with normal latency.
REQ-027 SDIV of the most negative value by -1 SHALL produce the most negative value (wrap), with no error indication.
REQ-028 result and wa_out SHALL hold their last values from DONE until the next DONE; they SHALL NOT change during RUN or FIX.
REQ-029 start asserted while busy=1 SHALL be ignored without being queued.
REQ-030 start in DONE SHALL be accepted, giving back-to-back operations with no idle cycle.
REQ-031 wa_out=31 SHALL still pulse we; suppressing the write to register 31 is the register file's responsibility.

Reset
REQ-032 reset=1 at a clock edge SHALL force state IDLE, busy=0, done=0, we=0, result=0, wa_out=0, counter=0, and clear the internal product/remainder registers.
REQ-033 Reset SHALL win over start in the same cycle.
REQ-034 Reset during RUN, FIX or DONE SHALL abort the operation with no done pulse.
REQ-035 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-036 MUL a=7, b=6, wa_in=3 -> busy for cycles 1..65; done=we=1 at cycle 66 with result=42, wa_out=3; done=0 at cycle 67.
REQ-037 UMULH a=0xFFFF_FFFF_FFFF_FFFF, b=2 -> result=1; MUL with the same operands -> result=0xFFFF_FFFF_FFFF_FFFE.
REQ-038 UDIV 100/7 -> result 14; UDIV 5/0 -> result 0; SDIV 5/0 -> result 0.
REQ-039 SDIV -100/7 -> result -14; SDIV -100/-7 -> result 14; SDIV 0x8000_0000_0000_0000/-1 -> result 0x8000_0000_0000_0000.
REQ-040 Start MUL 3*3, pulse start with UDIV 9/3 at cycle 10 -> one done only, at cycle 66, result=9; start again in that DONE cycle -> next done exactly 66 cycles later.
REQ-041 Reset asserted at cycle 20 of RUN -> next cycle busy=0, done=0, result=0; no done in the following 70 cycles without start.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative integer multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with register-file write-back outputs.
module muldiv_unit #(
  parameter int WIDTH = 64,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [AW-1:0]    wa_in,
  output logic             busy,
  output logic             done,
  output logic             we,
  output logic [WIDTH-1:0] result,
  output logic [AW-1:0]    wa_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_UDIV  = 2'b10;
  localparam logic [1:0] OP_SDIV  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [1:0]         op_q;
  logic [AW-1:0]      wa_q;
  logic               neg_q;
  logic               dz_q;
  // Shared datapath: low half holds multiplier / dividend-then-quotient,
  // high half accumulates the product / holds the partial remainder.
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   dsr;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               fits;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] n;
    n = -v;
    return v[WIDTH-1] ? $unsigned(n) : $unsigned(v);
  endfunction

  // Final result selection; divide-by-zero forces 0 and the most negative
  // quotient wraps naturally through two's-complement negation.
  function automatic logic [WIDTH-1:0] select_result(
    input logic [1:0]         sel,
    input logic [2*WIDTH-1:0] p,
    input logic               neg,
    input logic               dz
  );
    logic signed [WIDTH-1:0] q;
    logic signed [WIDTH-1:0] nq;
    q  = $signed(p[WIDTH-1:0]);
    nq = -q;
    case (sel)
      OP_MUL:   return p[WIDTH-1:0];
      OP_UMULH: return p[2*WIDTH-1:WIDTH];
      OP_UDIV:  return dz ? '0 : p[WIDTH-1:0];
      default:  return dz ? '0 : (neg ? $unsigned(nq) : $unsigned(q));
    endcase
  endfunction

  always_comb begin
    add_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]};
    if (prod[0]) add_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, dsr};
    mul_next = {add_sum, prod[WIDTH-1:1]};

    shifted  = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    fits     = (shifted >= {1'b0, dsr});
    diff     = shifted[WIDTH-1:0] - dsr;
    div_next = {(fits ? diff : shifted[WIDTH-1:0]), prod[WIDTH-2:0], fits};
  end

  assign we = done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      wa_out <= '0;
      cnt    <= '0;
      prod   <= '0;
      dsr    <= '0;
      op_q   <= OP_MUL;
      wa_q   <= '0;
      neg_q  <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= CW'(WIDTH - 1);
            op_q  <= op;
            wa_q  <= wa_in;
            neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
            dz_q  <= (b == '0);
            case (op)
              OP_MUL, OP_UMULH: begin
                prod <= {{WIDTH{1'b0}}, b};
                dsr  <= a;
              end
              OP_UDIV: begin
                prod <= {{WIDTH{1'b0}}, a};
                dsr  <= b;
              end
              default: begin
                prod <= {{WIDTH{1'b0}}, magnitude($signed(a))};
                dsr  <= magnitude($signed(b));
              end
            endcase
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          prod <= op_q[1] ? div_next : mul_next;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          result <= select_result(op_q, prod, neg_q, dz_q);
          wa_out <= wa_q;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: expected results are queued at start and
// compared when done pulses, together with latency and hold behaviour.
module tb_muldiv_unit;
  localparam int W = 64;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [A-1:0] wa_in;
  logic         busy;
  logic         done;
  logic         we;
  logic [W-1:0] result;
  logic [A-1:0] wa_out;

  int total  = 0;
  int passed = 0;

  logic [W-1:0] sb_res[$];
  logic [A-1:0] sb_wa[$];

  muldiv_unit #(.WIDTH(W), .AW(A)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .wa_in(wa_in), .busy(busy), .done(done), .we(we), .result(result),
    .wa_out(wa_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Independent reference: wide product, native divide, explicit edge cases.
  function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    logic [W-1:0]   minv;
    minv = {1'b1, {(W-1){1'b0}}};
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      2'b00: return p[W-1:0];
      2'b01: return p[2*W-1:W];
      2'b10: return (y == '0) ? '0 : x / y;
      default: begin
        if (y == '0) return '0;
        if (x == minv && y == '1) return minv;
        return $unsigned($signed(x) / $signed(y));
      end
    endcase
  endfunction

  // Called at a negedge with the DUT idle or in DONE; returns at the
  // negedge of cycle 1 with inputs scrambled to prove they were captured.
  task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [A-1:0] w, input logic [W-1:0] er);
    start = 1'b1; op = o; a = x; b = y; wa_in = w;
    sb_res.push_back(er);
    sb_wa.push_back(w);
    @(negedge clk);
    start = 1'b0; op = ~o; a = {$urandom, $urandom}; b = {$urandom, $urandom}; wa_in = ~w;
  endtask

  task automatic finish_op(input int c0, input string tag);
    int           c = c0;
    logic [W-1:0] r0 = result;
    logic [A-1:0] w0 = wa_out;
    bit           steady = 1'b1;
    logic [W-1:0] er;
    logic [A-1:0] ew;
    while (done !== 1'b1 && c < 100) begin
      if (busy !== 1'b1 || result !== r0 || wa_out !== w0) steady = 1'b0;
      @(negedge clk);
      c++;
    end
    check({tag, " latency"}, W'(c), W'(66));
    check({tag, " busy/hold during run"}, W'(steady), W'(1));
    check({tag, " busy at done"}, W'(busy), W'(0));
    check({tag, " we"}, W'(we), W'(1));
    er = 'x; ew = 'x;
    if (sb_res.size() > 0) begin
      er = sb_res.pop_front();
      ew = sb_wa.pop_front();
    end
    check({tag, " result"}, result, er);
    check({tag, " wa_out"}, W'(wa_out), W'(ew));
  endtask

  initial begin
    int pulses;
    logic [W-1:0] x, y;
    logic [1:0]   o;

    reset = 1'b1; start = 1'b1; op = 2'b00; a = 7; b = 6; wa_in = 3;
    repeat (3) @(negedge clk);
    reset = 1'b0; start = 1'b0;
    check("reset busy", W'(busy), W'(0));
    check("reset done", W'(done), W'(0));
    check("reset we", W'(we), W'(0));
    check("reset result", result, '0);
    check("reset wa_out", W'(wa_out), W'(0));
    @(negedge clk);
    check("reset beats start", W'(busy), W'(0));

    start_op(2'b00, 64'd7, 64'd6, 5'd3, 64'd42);
    finish_op(1, "mul 7*6");
    @(negedge clk);
    check("done cleared", W'(done), W'(0));
    check("we cleared", W'(we), W'(0));
    check("result held in idle", result, 64'd42);

    start_op(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd5, 64'd1);
    finish_op(1, "umulh");
    start_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFE);
    finish_op(1, "mul max*2");
    start_op(2'b10, 64'd100, 64'd7, 5'd7, 64'd14);
    finish_op(1, "udiv 100/7");
    start_op(2'b10, 64'd5, 64'd0, 5'd8, 64'd0);
    finish_op(1, "udiv 5/0");
    start_op(2'b11, 64'd5, 64'd0, 5'd9, 64'd0);
    finish_op(1, "sdiv 5/0");
    start_op(2'b11, -64'sd100, 64'd7, 5'd10, -64'sd14);
    finish_op(1, "sdiv -100/7");
    start_op(2'b11, -64'sd100, -64'sd7, 5'd11, 64'd14);
    finish_op(1, "sdiv -100/-7");
    start_op(2'b11, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 64'h8000_0000_0000_0000);
    finish_op(1, "sdiv min/-1 wa31");

    for (int i = 0; i < 6; i++) begin
      o = 2'(i % 4);
      x = {$urandom, $urandom};
      y = {$urandom, $urandom} >> $urandom_range(0, 60);
      start_op(o, x, y, 5'(i + 12), model(o, x, y));
      finish_op(1, "random op");
    end

    start_op(2'b00, 64'd3, 64'd3, 5'd4, 64'd9);
    repeat (9) @(negedge clk);
    start = 1'b1; op = 2'b10; a = 64'd9; b = 64'd3; wa_in = 5'd20;
    @(negedge clk);
    start = 1'b0;
    finish_op(11, "mul 3*3 ignoring start");
    start_op(2'b10, 64'd9, 64'd3, 5'd2, 64'd3);
    finish_op(1, "back-to-back udiv");
    pulses = 0;
    repeat (70) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("no queued op", W'(pulses), W'(0));

    start_op(2'b00, 64'd11, 64'd13, 5'd1, 64'd143);
    void'(sb_res.pop_back());
    void'(sb_wa.pop_back());
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort busy", W'(busy), W'(0));
    check("abort done", W'(done), W'(0));
    check("abort result", result, '0);
    check("abort wa_out", W'(wa_out), W'(0));
    pulses = 0;
    repeat (70) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("no done after abort", W'(pulses), W'(0));

    start_op(2'b00, 64'd7, 64'd6, 5'd3, 64'd42);
    finish_op(1, "mul after reset");
    check("scoreboard drained", W'(sb_res.size()), W'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
